memory_dp_cfg: RTL and testbench

Parametrised simple dual-port memory tile for the eFPGA fabric. It succeeds the fixed 1K×8 memory tile with parametrised depth and width, and a configurable aspect ratio (×W, ×W/2, ×W/4). It adds a configurable read-during-write policy, an optional output pipeline register and a read-valid strobe. It sits under the grid memory tile wrapper; mode and policy inputs are driven from fabric configuration bits.

---
 rtl/memory_cfg_pkg.sv | 16 +
 rtl/memory_dp_array.sv | 23 ++
 rtl/memory_dp_cfg.sv | 97 +++++++++
 tb/tb_memory_dp_cfg.sv | 125 ++++++++++++
 4 files changed

// File: rtl/memory_cfg_pkg.sv
// memory_cfg_pkg: aspect-mode enum and address/lane helper functions for the memory tile
package memory_cfg_pkg;
   typedef enum logic [1:0] {MODE_X1 = 2'd0, MODE_X2 = 2'd1, MODE_X4 = 2'd2} mode_t;
   function automatic mode_t to_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_X4 : mode_t'(m);
   endfunction
   function automatic int lane_width(input mode_t mode, input int data_w);
      return data_w >> int'(mode);
   endfunction
   function automatic int row_index(input int addr, input mode_t mode, input int addr_w);
      return (addr >> int'(mode)) & ((1 << addr_w) - 1);
   endfunction
   function automatic int lane_index(input int addr, input mode_t mode);
      return addr & ((1 << int'(mode)) - 1);
   endfunction
endpackage

// File: rtl/memory_dp_array.sv
// memory_dp_array: 2^ADDR_W x DATA_W storage with per-bit write mask and synchronous read
module memory_dp_array #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_wmask,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_rdata;
   // masked write and read-before-write synchronous read
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
      if (i_re) r_rdata <= r_mem[i_raddr];
   end
   assign o_rdata = r_rdata;
endmodule

// File: rtl/memory_dp_cfg.sv
// memory_dp_cfg: dual-port memory tile with aspect modes, RDW policy and optional output register
module memory_dp_cfg
   import memory_cfg_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 8,
   parameter int OUT_REG = 0
) (
   input  logic              memory_clk,
   input  logic              memory_reset,
   input  logic [1:0]        cfg_mode,
   input  logic              cfg_rdw_new,
   input  logic [ADDR_W+1:0] memory_waddr,
   input  logic [ADDR_W+1:0] memory_raddr,
   input  logic [DATA_W-1:0] memory_data_in,
   input  logic              memory_wen,
   input  logic              memory_ren,
   output logic [DATA_W-1:0] memory_data_out,
   output logic              memory_rvalid
);
   mode_t             w_mode;
   int                w_lw, w_wlane, w_rlane;
   logic [ADDR_W-1:0] w_wrow, w_rrow;
   logic [DATA_W-1:0] w_lmask, w_wmask, w_wdata, w_rdata, w_row, w_d1;
   logic              w_we, w_re;
   logic              r_hit, r_rdw_new, r_v1, r_clr;
   logic [DATA_W-1:0] r_mask, r_wdata, r_lmask;
   int                r_shift;
   // address decode, lane mask and write-data alignment
   always_comb begin
      w_mode  = to_mode(cfg_mode);
      w_lw    = lane_width(w_mode, DATA_W);
      w_wrow  = ADDR_W'(row_index(int'(memory_waddr), w_mode, ADDR_W));
      w_rrow  = ADDR_W'(row_index(int'(memory_raddr), w_mode, ADDR_W));
      w_wlane = lane_index(int'(memory_waddr), w_mode);
      w_rlane = lane_index(int'(memory_raddr), w_mode);
      w_lmask = {DATA_W{1'b1}} >> (DATA_W - w_lw);
      w_wmask = w_lmask << (w_wlane * w_lw);
      w_wdata = (memory_data_in & w_lmask) << (w_wlane * w_lw);
      w_we    = memory_wen & ~memory_reset;
      w_re    = memory_ren & ~memory_reset;
   end
   memory_dp_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
      .i_clk   (memory_clk),
      .i_we    (w_we),
      .i_waddr (w_wrow),
      .i_wdata (w_wdata),
      .i_wmask (w_wmask),
      .i_re    (w_re),
      .i_raddr (w_rrow),
      .o_rdata (w_rdata)
   );
   // capture the read context so the first stage holds its value while ren is low
   always_ff @(posedge memory_clk) begin
      if (memory_reset) begin
         r_v1  <= 1'b0;
         r_clr <= 1'b1;
      end else begin
         r_v1 <= memory_ren;
         if (memory_ren) begin
            r_clr     <= 1'b0;
            r_hit     <= w_we && (w_wrow == w_rrow);
            r_rdw_new <= cfg_rdw_new;
            r_mask    <= w_wmask;
            r_wdata   <= w_wdata;
            r_lmask   <= w_lmask;
            r_shift   <= w_rlane * w_lw;
         end
      end
   end
   // merge the colliding write lane when new-data policy is selected, then extract the read lane
   always_comb begin
      w_row = (r_hit && r_rdw_new) ? ((w_rdata & ~r_mask) | (r_wdata & r_mask)) : w_rdata;
      w_d1  = r_clr ? '0 : ((w_row >> r_shift) & r_lmask);
   end
   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] r_dout;
         logic              r_v2;
         // second output stage, loads only on a completed first-stage read
         always_ff @(posedge memory_clk) begin
            if (memory_reset) begin
               r_dout <= '0;
               r_v2   <= 1'b0;
            end else begin
               r_v2 <= r_v1;
               if (r_v1) r_dout <= w_d1;
            end
         end
         assign memory_data_out = r_dout;
         assign memory_rvalid   = r_v2;
      end else begin : g_noreg
         assign memory_data_out = w_d1;
         assign memory_rvalid   = r_v1;
      end
   endgenerate
endmodule

// File: tb/tb_memory_dp_cfg.sv
// tb_memory_dp_cfg: scoreboard bench driving OUT_REG=0 and OUT_REG=1 tiles in lockstep
module tb_memory_dp_cfg;
   logic        clk = 1'b0, rst = 1'b1, rdw = 1'b0, wen = 1'b0, ren = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [11:0] waddr = '0, raddr = '0;
   logic [7:0]  din = '0, d0, d1, e0, e1;
   logic        rv0, rv1;
   logic [7:0]  q0[$], q1[$];
   int          n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   memory_dp_cfg #(.ADDR_W(10), .DATA_W(8), .OUT_REG(0)) u0 (
      .memory_clk(clk), .memory_reset(rst), .cfg_mode(mode), .cfg_rdw_new(rdw),
      .memory_waddr(waddr), .memory_raddr(raddr), .memory_data_in(din),
      .memory_wen(wen), .memory_ren(ren), .memory_data_out(d0), .memory_rvalid(rv0));
   memory_dp_cfg #(.ADDR_W(10), .DATA_W(8), .OUT_REG(1)) u1 (
      .memory_clk(clk), .memory_reset(rst), .cfg_mode(mode), .cfg_rdw_new(rdw),
      .memory_waddr(waddr), .memory_raddr(raddr), .memory_data_in(din),
      .memory_wen(wen), .memory_ren(ren), .memory_data_out(d1), .memory_rvalid(rv1));
   // monitor: pop and compare whenever a tile presents rvalid
   always @(negedge clk) begin
      if (rv0) begin
         n_tests++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL rd_lat1 unexpected rvalid data=%h", d0);
         end else begin
            e0 = q0.pop_front();
            if (d0 !== e0) begin
               n_fail++;
               $display("FAIL rd_lat1 got=%h exp=%h", d0, e0);
            end
         end
      end
      if (rv1) begin
         n_tests++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL rd_lat2 unexpected rvalid data=%h", d1);
         end else begin
            e1 = q1.pop_front();
            if (d1 !== e1) begin
               n_fail++;
               $display("FAIL rd_lat2 got=%h exp=%h", d1, e1);
            end
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask
   task automatic wr(input logic [11:0] a, input logic [7:0] d);
      wen = 1'b1; waddr = a; din = d;
      step();
      wen = 1'b0;
   endtask
   task automatic rd(input logic [11:0] a, input logic [7:0] exp);
      ren = 1'b1; raddr = a;
      q0.push_back(exp); q1.push_back(exp);
      step();
      ren = 1'b0;
   endtask
   initial begin
      #1;
      repeat (3) step();
      chk("rst_dout0", d0, 8'h00);
      chk("rst_dout1", d1, 8'h00);
      chk("rst_rv0", {7'b0, rv0}, 8'h00);
      chk("rst_rv1", {7'b0, rv1}, 8'h00);
      rst = 1'b0;
      wr(12'd5, 8'hA5);
      rd(12'd5, 8'hA5);
      repeat (3) step();
      chk("hold_dout0", d0, 8'hA5);
      chk("hold_dout1", d1, 8'hA5);
      chk("hold_rv1", {7'b0, rv1}, 8'h00);
      mode = 2'd1;
      wr(12'd10, 8'h03);
      wr(12'd11, 8'h0C);
      mode = 2'd0; rd(12'd5, 8'hC3);
      mode = 2'd1; rd(12'd11, 8'h0C);
      mode = 2'd2;
      rd(12'd22, 8'h00);
      rd(12'd23, 8'h03);
      mode = 2'd3; rd(12'd23, 8'h03);
      mode = 2'd2; wr(12'd21, 8'h02);
      mode = 2'd0; rd(12'd5, 8'hCB);
      wr(12'd7, 8'h11);
      rdw = 1'b0; wen = 1'b1; waddr = 12'd7; din = 8'h22; rd(12'd7, 8'h11);
      wr(12'd7, 8'h11);
      rdw = 1'b1; wen = 1'b1; waddr = 12'd7; din = 8'h22; rd(12'd7, 8'h22);
      rd(12'd7, 8'h22);
      mode = 2'd1; wen = 1'b1; waddr = 12'd14; din = 8'h09; rd(12'd15, 8'h02);
      rd(12'd14, 8'h09);
      mode = 2'd0; rdw = 1'b0;
      wr(12'd5, 8'hA5);
      ren = 1'b1; raddr = 12'd5; q0.push_back(8'hA5);
      step();
      ren = 1'b0; rst = 1'b1; wen = 1'b1; waddr = 12'd5; din = 8'hFF;
      step();
      chk("rstmid_rv1", {7'b0, rv1}, 8'h00);
      chk("rstmid_dout1", d1, 8'h00);
      chk("rstmid_dout0", d0, 8'h00);
      step();
      rst = 1'b0; wen = 1'b0;
      step();
      chk("rstpost_rv1", {7'b0, rv1}, 8'h00);
      rd(12'd5, 8'hA5);
      for (int i = 0; i < 4; i++) wr(12'(i), 8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) rd(12'(i), 8'h10 + 8'(i));
      for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) step();
      step();
      chk("drain_q0", 8'(q0.size()), 8'h00);
      chk("drain_q1", 8'(q1.size()), 8'h00);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
